// File: rtl/fast_to_slow_req_arbiter.sv
// Fast-domain arbiter feeding the shared fast-to-slow pulse stretcher.
// Define FTS_ARB_FIXED_PRI_EN for fixed priority (lowest index wins); default is round-robin.
module fast_to_slow_req_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int ID_W           = 2,
  parameter int STRETCH_CYCLES = 4,
  parameter int GAP_CYCLES     = 1
) (
  input  logic               clk_fast,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic               sig_out,
  output logic [ID_W-1:0]    id_out,
  output logic               busy
);

  localparam int MAX_SG     = (STRETCH_CYCLES > GAP_CYCLES) ? STRETCH_CYCLES : GAP_CYCLES;
  localparam int MAX_C      = (MAX_SG > 2) ? MAX_SG : 2;
  localparam int CNT_W      = $clog2(MAX_C) + 1;
  localparam int REQ_EXT_W  = 1 << ID_W;
  localparam int GAP_INIT_I = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  localparam logic [CNT_W-1:0]   HOLD_INIT = CNT_W'(STRETCH_CYCLES - 1);
  localparam logic [CNT_W-1:0]   GAP_INIT  = CNT_W'(GAP_INIT_I);
  localparam logic [NUM_REQ-1:0] ONE_REQ   = NUM_REQ'(1);
  localparam logic [ID_W:0]      NREQ_EXT  = (ID_W+1)'(NUM_REQ);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
  logic [NUM_REQ-1:0]   r_grant, w_grant_nxt;
  logic [ID_W-1:0]      r_id, w_id_nxt;

  logic [REQ_EXT_W-1:0] w_req_ext;
  logic [ID_W-1:0]      w_start;
  logic [ID_W-1:0]      w_win;
  logic                 w_found;
  logic [ID_W:0]        w_sum;
  logic [NUM_REQ-1:0]   w_onehot;

  // Widening to 2**ID_W lets any ID_W-bit index select safely; missing requesters read 0.
  assign w_req_ext = REQ_EXT_W'(req);

`ifdef FTS_ARB_FIXED_PRI_EN
  assign w_start = '0;
`else
  logic [ID_W-1:0] r_ptr;
  assign w_start = r_ptr;

  always_ff @(posedge clk_fast) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (r_state == ST_IDLE && w_found) begin
      if (w_win == ID_W'(NUM_REQ - 1)) r_ptr <= '0;
      else                             r_ptr <= w_win + ID_W'(1);
    end
  end
`endif

  // Search NUM_REQ slots starting at w_start, wrapping at NUM_REQ.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_sum   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_sum = {1'b0, w_start} + (ID_W+1)'(i);
      if (w_sum >= NREQ_EXT) w_sum = w_sum - NREQ_EXT;
      if (!w_found && w_req_ext[w_sum[ID_W-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_sum[ID_W-1:0];
      end
    end
  end

  assign w_onehot = ONE_REQ << w_win;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_grant_nxt = '0;
    w_id_nxt    = r_id;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_nxt = ST_HOLD;
          w_cnt_nxt   = HOLD_INIT;
          w_grant_nxt = w_onehot;
          w_id_nxt    = w_win;
        end
      end
      ST_HOLD: begin
        if (r_cnt == '0) begin
          if (GAP_CYCLES == 0) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
          end else begin
            w_state_nxt = ST_GAP;
            w_cnt_nxt   = GAP_INIT;
          end
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_fast) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_grant <= '0;
      r_id    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_grant <= w_grant_nxt;
      r_id    <= w_id_nxt;
    end
  end

  assign grant   = r_grant;
  assign sig_out = |r_grant;
  assign id_out  = r_id;
  assign busy    = (r_state != ST_IDLE);

endmodule
